pht_update_scheduler: RTL and testbench

//  Controller for the 2-bit pattern history table (PHT). Forms the gshare read index from the fetch PC and a speculative global history register (GHR).

---
 rtl/pht_update_scheduler.sv | 183 ++++++++++++++++++
 tb/tb_pht_update_scheduler.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pht_update_scheduler.sv
// pht_update_scheduler
// Gshare index generation, speculative GHR with mispredict repair, and a
// small update queue that drains resolved-branch outcomes onto the single
// PHT write port. Writes that hit the row/column being read this cycle are
// deferred, but never for more than MAX_DEFER consecutive cycles.
// Optional feature macro: BP_PERF_CNT_EN adds saturating prediction and
// mispredict counters (perf_pred_cnt, perf_mispred_cnt).
module pht_update_scheduler #(
  parameter int ROW_IDX_WIDTH = 6,
  parameter int COL_IDX_WIDTH = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_DEFER     = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              fetch_pc,
  input  logic                     fetch_valid,
  input  logic                     fetch_is_br,
  input  logic                     pht_br_taken,
  output logic [ROW_IDX_WIDTH-1:0] read_row_idx,
  output logic [COL_IDX_WIDTH-1:0] read_col_idx,
  output logic                     pred_taken,
  output logic [ROW_IDX_WIDTH-1:0] pred_ghr,
  input  logic                     res_valid,
  output logic                     res_ready,
  input  logic [31:0]              res_pc,
  input  logic [ROW_IDX_WIDTH-1:0] res_ghr,
  input  logic                     res_taken,
  input  logic                     res_mispredict,
  output logic                     load_pht,
  output logic                     br_en_out,
  output logic [ROW_IDX_WIDTH-1:0] write_row_idx,
  output logic [COL_IDX_WIDTH-1:0] write_col_idx
`ifdef BP_PERF_CNT_EN
  ,
  output logic [31:0]              perf_pred_cnt,
  output logic [31:0]              perf_mispred_cnt
`endif
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W   = PTR_W + 1;
  localparam int DEF_W   = (MAX_DEFER > 0) ? $clog2(MAX_DEFER + 1) : 1;
  localparam int ROW_LSB = 2 + COL_IDX_WIDTH;

  localparam logic [CNT_W-1:0] DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [DEF_W-1:0] MAX_DEFER_C = DEF_W'(MAX_DEFER);
  localparam logic [PTR_W-1:0] PTR_ONE_C   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE_C   = CNT_W'(1);
  localparam logic [DEF_W-1:0] DEF_ONE_C   = DEF_W'(1);

  logic [ROW_IDX_WIDTH-1:0] ghr_spec_r;
  logic [ROW_IDX_WIDTH-1:0] row_mem_r   [FIFO_DEPTH];
  logic [COL_IDX_WIDTH-1:0] col_mem_r   [FIFO_DEPTH];
  logic                     taken_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_r;
  logic [PTR_W-1:0]         rd_ptr_r;
  logic [CNT_W-1:0]         count_r;
  logic [DEF_W-1:0]         defer_cnt_r;

  logic                     empty_s;
  logic                     full_s;
  logic                     enq_s;
  logic                     pop_s;
  logic                     collide_s;
  logic [ROW_IDX_WIDTH-1:0] head_row_s;
  logic [COL_IDX_WIDTH-1:0] head_col_s;
  logic                     head_taken_s;
  logic [ROW_IDX_WIDTH-1:0] enq_row_s;
  logic [COL_IDX_WIDTH-1:0] enq_col_s;
  logic                     unused_s;

  // PC bits outside the gshare index window are intentionally ignored.
  assign unused_s = ^{fetch_pc[31:ROW_LSB+ROW_IDX_WIDTH], fetch_pc[1:0],
                      res_pc[31:ROW_LSB+ROW_IDX_WIDTH], res_pc[1:0]};

  // Gshare read/write index formation and the prediction handed to fetch.
  always_comb begin
    read_col_idx = fetch_pc[2 +: COL_IDX_WIDTH];
    read_row_idx = fetch_pc[ROW_LSB +: ROW_IDX_WIDTH] ^ ghr_spec_r;
    pred_taken   = fetch_is_br & pht_br_taken;
    pred_ghr     = ghr_spec_r;
    enq_col_s    = res_pc[2 +: COL_IDX_WIDTH];
    enq_row_s    = res_pc[ROW_LSB +: ROW_IDX_WIDTH] ^ res_ghr;
  end

  // Queue status, head decode and drain arbitration against the live lookup.
  always_comb begin
    empty_s   = (count_r == {CNT_W{1'b0}});
    full_s    = (count_r == DEPTH_C);
    res_ready = !full_s && !rst;
    enq_s     = res_valid && res_ready;
    if (empty_s) begin
      head_row_s   = {ROW_IDX_WIDTH{1'b0}};
      head_col_s   = {COL_IDX_WIDTH{1'b0}};
      head_taken_s = 1'b0;
    end else begin
      head_row_s   = row_mem_r[rd_ptr_r];
      head_col_s   = col_mem_r[rd_ptr_r];
      head_taken_s = taken_mem_r[rd_ptr_r];
    end
    collide_s     = fetch_valid && fetch_is_br &&
                    ({head_row_s, head_col_s} == {read_row_idx, read_col_idx});
    load_pht      = !rst && !empty_s && (!collide_s || (defer_cnt_r == MAX_DEFER_C));
    pop_s         = load_pht;
    write_row_idx = head_row_s;
    write_col_idx = head_col_s;
    br_en_out     = head_taken_s;
  end

  // Speculative GHR: mispredict repair wins over the fetch-side shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_spec_r <= {ROW_IDX_WIDTH{1'b0}};
    end else if (enq_s && res_mispredict) begin
      ghr_spec_r <= {res_ghr[ROW_IDX_WIDTH-2:0], res_taken};
    end else if (fetch_valid && fetch_is_br) begin
      ghr_spec_r <= {ghr_spec_r[ROW_IDX_WIDTH-2:0], pred_taken};
    end else begin
      ghr_spec_r <= ghr_spec_r;
    end
  end

  // Circular update queue; reset discards every pending update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        row_mem_r[i]   <= {ROW_IDX_WIDTH{1'b0}};
        col_mem_r[i]   <= {COL_IDX_WIDTH{1'b0}};
        taken_mem_r[i] <= 1'b0;
      end
    end else begin
      if (enq_s) begin
        row_mem_r[wr_ptr_r]   <= enq_row_s;
        col_mem_r[wr_ptr_r]   <= enq_col_s;
        taken_mem_r[wr_ptr_r] <= res_taken;
        wr_ptr_r              <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      case ({enq_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE_C;
        2'b01:   count_r <= count_r - CNT_ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Consecutive-deferral counter; reaching MAX_DEFER forces the next write.
  always_ff @(posedge clk) begin
    if (rst) begin
      defer_cnt_r <= {DEF_W{1'b0}};
    end else if (pop_s || empty_s) begin
      defer_cnt_r <= {DEF_W{1'b0}};
    end else if (collide_s) begin
      defer_cnt_r <= defer_cnt_r + DEF_ONE_C;
    end else begin
      defer_cnt_r <= defer_cnt_r;
    end
  end

`ifdef BP_PERF_CNT_EN
  // Saturating counts of predicted branches and accepted mispredicts.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_pred_cnt    <= 32'd0;
      perf_mispred_cnt <= 32'd0;
    end else begin
      if (fetch_valid && fetch_is_br && (perf_pred_cnt != 32'hFFFF_FFFF)) begin
        perf_pred_cnt <= perf_pred_cnt + 32'd1;
      end
      if (enq_s && res_mispredict && (perf_mispred_cnt != 32'hFFFF_FFFF)) begin
        perf_mispred_cnt <= perf_mispred_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pht_update_scheduler.sv
// Directed bench for pht_update_scheduler: a default instance (MAX_DEFER=3)
// and a second instance (MAX_DEFER=7) share all inputs.
module tb_pht_update_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        fetch_valid;
  logic        fetch_is_br;
  logic        pht_br_taken;
  logic        res_valid;
  logic [31:0] res_pc;
  logic [5:0]  res_ghr;
  logic        res_taken;
  logic        res_mispredict;

  logic [5:0]  read_row_idx, pred_ghr, write_row_idx;
  logic [2:0]  read_col_idx, write_col_idx;
  logic        pred_taken, res_ready, load_pht, br_en_out;

  logic [5:0]  d7_read_row_idx, d7_pred_ghr, d7_write_row_idx;
  logic [2:0]  d7_read_col_idx, d7_write_col_idx;
  logic        d7_pred_taken, d7_res_ready, d7_load_pht, d7_br_en_out;

`ifdef BP_PERF_CNT_EN
  logic [31:0] perf_pred_cnt, perf_mispred_cnt;
  logic [31:0] d7_perf_pred_cnt, d7_perf_mispred_cnt;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pht_update_scheduler u_dut (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
    .fetch_is_br(fetch_is_br), .pht_br_taken(pht_br_taken),
    .read_row_idx(read_row_idx), .read_col_idx(read_col_idx),
    .pred_taken(pred_taken), .pred_ghr(pred_ghr), .res_valid(res_valid),
    .res_ready(res_ready), .res_pc(res_pc), .res_ghr(res_ghr),
    .res_taken(res_taken), .res_mispredict(res_mispredict),
    .load_pht(load_pht), .br_en_out(br_en_out),
    .write_row_idx(write_row_idx), .write_col_idx(write_col_idx)
`ifdef BP_PERF_CNT_EN
    , .perf_pred_cnt(perf_pred_cnt), .perf_mispred_cnt(perf_mispred_cnt)
`endif
  );

  pht_update_scheduler #(.MAX_DEFER(7)) u_dut7 (
    .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .fetch_valid(fetch_valid),
    .fetch_is_br(fetch_is_br), .pht_br_taken(pht_br_taken),
    .read_row_idx(d7_read_row_idx), .read_col_idx(d7_read_col_idx),
    .pred_taken(d7_pred_taken), .pred_ghr(d7_pred_ghr), .res_valid(res_valid),
    .res_ready(d7_res_ready), .res_pc(res_pc), .res_ghr(res_ghr),
    .res_taken(res_taken), .res_mispredict(res_mispredict),
    .load_pht(d7_load_pht), .br_en_out(d7_br_en_out),
    .write_row_idx(d7_write_row_idx), .write_col_idx(d7_write_col_idx)
`ifdef BP_PERF_CNT_EN
    , .perf_pred_cnt(d7_perf_pred_cnt), .perf_mispred_cnt(d7_perf_mispred_cnt)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_pc = 32'd0; fetch_valid = 1'b0; fetch_is_br = 1'b0; pht_br_taken = 1'b0;
    res_valid = 1'b0; res_pc = 32'd0; res_ghr = 6'd0; res_taken = 1'b0;
    res_mispredict = 1'b0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    res_valid = 1'b1;
    tick();
    #1;
    checks++; if (load_pht !== 1'b0) begin errors++; $display("FAIL rst_load_pht: got %b want 0", load_pht); end
    checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL rst_res_ready: got %b want 0", res_ready); end
    rst = 1'b0;
    res_valid = 1'b0;
    #1;
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL post_rst_res_ready: got %b want 1", res_ready); end
    checks++; if (pred_ghr !== 6'd0) begin errors++; $display("FAIL post_rst_pred_ghr: got %h want 0", pred_ghr); end
    checks++; if (load_pht !== 1'b0) begin errors++; $display("FAIL post_rst_load_pht: got %b want 0", load_pht); end
  endtask

  task automatic test_index_predict();
    fetch_pc = 32'h48; fetch_valid = 1'b1; fetch_is_br = 1'b1; pht_br_taken = 1'b1;
    #1;
    checks++; if (read_row_idx !== 6'd2) begin errors++; $display("FAIL read_row: got %0d want 2", read_row_idx); end
    checks++; if (read_col_idx !== 3'd2) begin errors++; $display("FAIL read_col: got %0d want 2", read_col_idx); end
    checks++; if (pred_taken !== 1'b1) begin errors++; $display("FAIL pred_taken: got %b want 1", pred_taken); end
    tick();
    fetch_valid = 1'b0;
    #1;
    checks++; if (pred_ghr !== 6'b000001) begin errors++; $display("FAIL ghr_shift: got %b want 000001", pred_ghr); end
  endtask

  task automatic test_mispredict();
    // Fetch branch in the same cycle must be dropped in favour of repair.
    fetch_pc = 32'h48; fetch_valid = 1'b1; fetch_is_br = 1'b1; pht_br_taken = 1'b1;
    res_valid = 1'b1; res_pc = 32'h48; res_ghr = 6'b000011; res_taken = 1'b1; res_mispredict = 1'b1;
    #1;
    checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL mp_ready: got %b want 1", res_ready); end
    tick();
    idle_inputs();
    #1;
    checks++; if (pred_ghr !== 6'b000111) begin errors++; $display("FAIL mp_ghr: got %b want 000111", pred_ghr); end
    checks++; if (load_pht !== 1'b1) begin errors++; $display("FAIL mp_load: got %b want 1", load_pht); end
    checks++; if (write_row_idx !== 6'd1) begin errors++; $display("FAIL mp_wrow: got %0d want 1", write_row_idx); end
    checks++; if (write_col_idx !== 3'd2) begin errors++; $display("FAIL mp_wcol: got %0d want 2", write_col_idx); end
    checks++; if (br_en_out !== 1'b1) begin errors++; $display("FAIL mp_br_en: got %b want 1", br_en_out); end
`ifdef BP_PERF_CNT_EN
    checks++; if (perf_pred_cnt !== 32'd2) begin errors++; $display("FAIL perf_pred: got %0d want 2", perf_pred_cnt); end
    checks++; if (perf_mispred_cnt !== 32'd1) begin errors++; $display("FAIL perf_mispred: got %0d want 1", perf_mispred_cnt); end
`endif
    tick();
    checks++; if (load_pht !== 1'b0) begin errors++; $display("FAIL mp_drained: got %b want 0", load_pht); end
  endtask

  task automatic test_defer();
    apply_reset();
    res_valid = 1'b1; res_pc = 32'h48; res_ghr = 6'd0; res_taken = 1'b0;
    tick();
    res_valid = 1'b0;
    fetch_pc = 32'h48; fetch_valid = 1'b1; fetch_is_br = 1'b1; pht_br_taken = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (load_pht !== 1'b0) begin errors++; $display("FAIL defer_cycle%0d: got %b want 0", c, load_pht); end
      tick();
    end
    #1;
    checks++; if (load_pht !== 1'b1) begin errors++; $display("FAIL defer_forced: got %b want 1", load_pht); end
    checks++; if (write_row_idx !== 6'd2) begin errors++; $display("FAIL defer_wrow: got %0d want 2", write_row_idx); end
    checks++; if (br_en_out !== 1'b0) begin errors++; $display("FAIL defer_br_en: got %b want 0", br_en_out); end
    tick();
    checks++; if ({load_pht, write_row_idx, write_col_idx} !== 10'd0) begin errors++; $display("FAIL defer_empty: got %h want 0", {load_pht, write_row_idx, write_col_idx}); end
    // A fresh colliding update must again see the full deferral window.
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (load_pht !== 1'b0) begin errors++; $display("FAIL redefer_cycle%0d: got %b want 0", c, load_pht); end
      tick();
    end
    checks++; if (load_pht !== 1'b1) begin errors++; $display("FAIL redefer_forced: got %b want 1", load_pht); end
    tick();
  endtask

  task automatic test_backpressure();
    int accepts;
    int first_load;
    apply_reset();
    accepts = 0;
    first_load = -1;
    fetch_pc = 32'h48; fetch_valid = 1'b1; fetch_is_br = 1'b1; pht_br_taken = 1'b0;
    res_valid = 1'b1; res_pc = 32'h48; res_ghr = 6'd0; res_taken = 1'b1;
    for (int c = 0; c < 9; c++) begin
      #1;
      if (d7_res_ready) accepts++;
      if (d7_load_pht && first_load < 0) first_load = c;
      tick();
    end
    checks++; if (accepts !== 4) begin errors++; $display("FAIL bp_accepts: got %0d want 4", accepts); end
    checks++; if (first_load !== 8) begin errors++; $display("FAIL bp_forced_cycle: got %0d want 8", first_load); end
    checks++; if (d7_res_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_return: got %b want 1", d7_res_ready); end
    checks++; if (d7_load_pht !== 1'b0) begin errors++; $display("FAIL bp_after_pop: got %b want 0", d7_load_pht); end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    res_valid = 1'b1; res_pc = 32'h48; res_ghr = 6'd0; res_taken = 1'b1;
    tick();
    res_pc = 32'h104; res_ghr = 6'd0; res_taken = 1'b0;
    #1;
    checks++; if ({load_pht, write_row_idx, write_col_idx, br_en_out} !== {1'b1, 6'd2, 3'd2, 1'b1}) begin errors++; $display("FAIL b2b_a: got %b", {load_pht, write_row_idx, write_col_idx, br_en_out}); end
    tick();
    res_pc = 32'h7FC; res_ghr = 6'b111111; res_taken = 1'b1;
    #1;
    checks++; if ({load_pht, write_row_idx, write_col_idx, br_en_out} !== {1'b1, 6'd8, 3'd1, 1'b0}) begin errors++; $display("FAIL b2b_b: got %b", {load_pht, write_row_idx, write_col_idx, br_en_out}); end
    tick();
    res_valid = 1'b0;
    #1;
    checks++; if ({load_pht, write_row_idx, write_col_idx, br_en_out} !== {1'b1, 6'd0, 3'd7, 1'b1}) begin errors++; $display("FAIL b2b_c: got %b", {load_pht, write_row_idx, write_col_idx, br_en_out}); end
    tick();
    checks++; if (load_pht !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", load_pht); end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    fetch_pc = 32'h48; fetch_valid = 1'b1; fetch_is_br = 1'b1; pht_br_taken = 1'b0;
    res_valid = 1'b1; res_pc = 32'h48; res_ghr = 6'd0; res_taken = 1'b0;
    tick();
    res_ghr = 6'b000011; res_taken = 1'b1; res_mispredict = 1'b1;
    #1;
    checks++; if (load_pht !== 1'b0) begin errors++; $display("FAIL mr_deferred: got %b want 0", load_pht); end
    tick();
    res_valid = 1'b0; res_mispredict = 1'b0;
    #1;
    checks++; if (pred_ghr !== 6'b000111) begin errors++; $display("FAIL mr_ghr_before: got %b want 000111", pred_ghr); end
    rst = 1'b1;
    #1;
    checks++; if (load_pht !== 1'b0) begin errors++; $display("FAIL mr_load_in_rst: got %b want 0", load_pht); end
    checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL mr_ready_in_rst: got %b want 0", res_ready); end
    tick();
    rst = 1'b0;
    fetch_valid = 1'b0;
    #1;
    checks++; if (pred_ghr !== 6'd0) begin errors++; $display("FAIL mr_ghr: got %b want 0", pred_ghr); end
    checks++; if ({load_pht, write_row_idx, write_col_idx, br_en_out} !== 11'd0) begin errors++; $display("FAIL mr_empty: got %b want 0", {load_pht, write_row_idx, write_col_idx, br_en_out}); end
`ifdef BP_PERF_CNT_EN
    checks++; if ({perf_pred_cnt, perf_mispred_cnt} !== 64'd0) begin errors++; $display("FAIL mr_perf: got %h want 0", {perf_pred_cnt, perf_mispred_cnt}); end
`endif
    tick();
    checks++; if (load_pht !== 1'b0) begin errors++; $display("FAIL mr_still_empty: got %b want 0", load_pht); end
  endtask

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst = 1'b0;
    test_reset();
    test_index_predict();
    test_mispredict();
    test_defer();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
